// File: rtl/rep_monitor_pkg.sv
// Shared types for the repetition monitor: the mode and per-channel state encodings,
// the total_hits width, and a popcount helper.
package rep_pkg;

    typedef enum logic [1:0] {
        CONSEC    = 2'd0,
        GOTO      = 2'd1,
        NONCONSEC = 2'd2
    } mode_e;

    typedef enum logic {
        COUNT = 1'b0,
        MATCH = 1'b1
    } state_e;

    localparam int TOTAL_W = 16;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rep_monitor_channel.sv
// One monitored channel: counts event samples under the configured repetition mode
// and raises a registered hit (and, in NONCONSEC, an over pulse).
module rep_channel
    import rep_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  mode_e            i_mode,
    input  logic [CNT_W-1:0] i_target,
    input  logic             i_a,
    output logic             o_hit,
    output logic             o_over,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_hit_nxt,
    output state_e           o_state
);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_hit, w_hit_nxt;
    logic             r_over, w_over_nxt;
    logic             w_last;

    assign w_last = (r_cnt == i_target - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COUNT;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hit   <= w_hit_nxt;
            r_over  <= w_over_nxt;
        end
    end

    // A zero target disables matching, so it shares the restart path with clear.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hit_nxt   = 1'b0;
        w_over_nxt  = 1'b0;
        if (i_clear || (i_target == '0)) begin
            w_state_nxt = COUNT;
            w_cnt_nxt   = '0;
        end else if (i_en) begin
            case (r_state)
                COUNT: begin
                    if (i_a) begin
                        if (w_last) begin
                            w_hit_nxt = 1'b1;
                            if (i_mode == NONCONSEC) begin
                                w_state_nxt = MATCH;
                                w_cnt_nxt   = i_target;
                            end else begin
                                w_cnt_nxt = '0;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else if (i_mode == CONSEC) begin
                        w_cnt_nxt = '0;
                    end
                end
                MATCH: begin
                    if (i_a) begin
                        w_over_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = COUNT;
                    end else begin
                        w_hit_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = COUNT;
            endcase
        end
    end

    assign o_hit     = r_hit;
    assign o_over    = r_over;
    assign o_cnt     = r_cnt;
    assign o_hit_nxt = w_hit_nxt;
    assign o_state   = r_state;

endmodule

// File: rtl/rep_monitor.sv
// Multi-channel repetition monitor: latches mode/target on clear, runs one rep_channel
// per input bit and keeps a saturating count of hit rising edges across channels.
module rep_monitor
    import rep_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clear,
    input  logic [1:0]              mode,
    input  logic [CNT_W-1:0]        target,
    input  logic [NUM_CH-1:0]       a,
    output logic [NUM_CH-1:0]       hit,
    output logic [NUM_CH-1:0]       over,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic [TOTAL_W-1:0]      total_hits,
    output logic [NUM_CH-1:0]       dbg_state
);

    mode_e               r_mode;
    logic [CNT_W-1:0]    r_target;
    logic [TOTAL_W-1:0]  r_total;
    logic [NUM_CH-1:0]   w_hit_nxt;
    logic [NUM_CH-1:0]   w_rise;
    logic [31:0]         w_rise32;
    logic [5:0]          w_pop;
    logic [TOTAL_W:0]    w_sum;

    // The reserved mode encoding is folded into CONSEC when the config is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= CONSEC;
            r_target <= '0;
        end else if (clear) begin
            r_mode   <= (mode == 2'd3) ? CONSEC : mode_e'(mode);
            r_target <= target;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e w_state;
        rep_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_clear   (clear),
            .i_mode    (r_mode),
            .i_target  (r_target),
            .i_a       (a[g]),
            .o_hit     (hit[g]),
            .o_over    (over[g]),
            .o_cnt     (cnt[g*CNT_W +: CNT_W]),
            .o_hit_nxt (w_hit_nxt[g]),
            .o_state   (w_state)
        );
        assign dbg_state[g] = (w_state == MATCH);
    end

    // Rising edges are taken from next-vs-current hit so the total moves with hit itself.
    assign w_rise = w_hit_nxt & ~hit;

    always_comb begin
        w_rise32               = '0;
        w_rise32[NUM_CH-1:0]   = w_rise;
    end

    assign w_pop = popcount32(w_rise32);
    assign w_sum = (TOTAL_W+1)'(r_total) + (TOTAL_W+1)'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total <= '0;
        end else if (clear) begin
            r_total <= '0;
        end else if (en) begin
            r_total <= w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
        end
    end

    assign total_hits = r_total;

endmodule

// File: doc/rep_monitor.md
REP_MONITOR -- requirements
Module: rep_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent monitored channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of per-channel repetition counter and target.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  advance enable; 0 freezes all state.
REQ-006 SHALL have port clear  input  1  synchronous restart; loads mode/target config.
REQ-007 SHALL have port mode  input  2  repetition mode: 0 CONSEC, 1 GOTO, 2 NONCONSEC, 3 reserved (treated as CONSEC).
REQ-008 SHALL have port target  input  CNT_W  required repetition count N.
REQ-009 SHALL have port a  input  NUM_CH  sampled event bit per channel.
REQ-010 SHALL have port hit  output  NUM_CH  registered per-channel match flag.
REQ-011 SHALL have port over  output  NUM_CH  registered per-channel pulse: NONCONSEC extra event after match.
REQ-012 SHALL have port cnt  output  NUM_CH*CNT_W  per-channel current count, channel i at bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port total_hits  output  16  saturating count of hit rising edges over all channels.

Function
REQ-014 SHALL use mode_q/target_q registers, loaded only on reset (to CONSEC, 0) or clear; live mode/target changes otherwise ignored.
REQ-015 SHALL give each channel a 2-state FSM: COUNT, MATCH.
REQ-016 CONSEC: a=1 -> cnt+1; a=0 -> cnt=0; a=1 with cnt==target_q-1 -> hit=1 next cycle, cnt=0, stay COUNT (non-overlapping windows).
REQ-017 GOTO: a=1 -> cnt+1; a=0 -> cnt holds; a=1 with cnt==target_q-1 -> hit=1 next cycle, cnt=0, stay COUNT.
REQ-018 NONCONSEC: counting as GOTO; Nth a -> MATCH, cnt=target_q; in MATCH hit=1 every cycle while a=0; a=1 in MATCH -> over=1 one cycle, hit=0, cnt=0, COUNT.
REQ-019 hit SHALL be registered: one-cycle latency from the qualifying a sample; CONSEC/GOTO hit is a single-cycle pulse.
REQ-020 target_q==0 SHALL disable matching: cnt stays 0, hit/over stay 0, FSM stays COUNT.
REQ-021 target_q==1 SHALL produce a hit for every a=1 sample in CONSEC/GOTO.
REQ-022 cnt SHALL never exceed target_q; no wrap-around possible.
REQ-023 en=0 SHALL hold cnt, FSM, total_hits; hit and over forced 0 that cycle.
REQ-024 clear SHALL take priority over en: next cycle cnt=0, FSM=COUNT, hit=0, over=0, total_hits=0, config reloaded; a sampled with clear ignored.
REQ-025 total_hits SHALL add the number of channels whose hit rises (0->1) in the same cycle (popcount, up to NUM_CH), saturating at 16'hFFFF.
REQ-026 Channels SHALL be fully independent; simultaneous hits on all channels SHALL all be reported and counted.

Reset
REQ-027 rst=1 SHALL asynchronously force cnt=0, FSM=COUNT, hit=0, over=0, total_hits=0, mode_q=CONSEC, target_q=0.
REQ-028 Reset asserted mid-count SHALL discard partial counts; after deassertion matching stays disabled until a clear loads a nonzero target.

Structure
REQ-029 Package rep_pkg SHALL hold mode_e enum (CONSEC, GOTO, NONCONSEC), state_e enum (COUNT, MATCH) and TOTAL_W=16.
REQ-030 Per-channel logic SHALL live in sub-module rep_channel, instantiated NUM_CH times by generate; popcount/total_hits in top.

Verification
REQ-031 CONSEC, target=5, ch0 a=1 for 5 cycles -> hit[0]=1 one cycle after 5th sample; 10 consecutive a -> exactly 2 hits; a pattern 1111 0 11111 -> 1 hit.
REQ-032 GOTO, target=3, a=1,0,0,1,0,1 -> hit pulse after 6th sample; cnt 1,1,1,2,2,0.
REQ-033 NONCONSEC, target=2, a=1,0,1,0,0,1 -> hit high 3 cycles after 3rd sample, over=1 after 6th sample, cnt=0.
REQ-034 NUM_CH=4, CONSEC target=1, a=4'hF for 3 cycles -> hit=4'hF each cycle, total_hits=4 (hit stays high, one rising edge each); preload total_hits near 16'hFFFF -> saturates, no wrap.
REQ-035 rst pulsed mid-count (cnt=3) asynchronously -> cnt=0, hit=0 immediately; en=0 for 2 cycles with a=1 -> cnt unchanged.
REQ-036 clear with mode=GOTO target=4 while en=0 -> config loaded, counts zeroed; target=0 after clear -> no hit under any a.
